freq_meter_50m: RTL
===================

FREQ_METER_50M -- requirements
Module: freq_meter_50m

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50_000_000: gate length in clk_50m cycles (1 s).
REQ-002 SHALL have parameter LOSS_CYCLES, default 37_500_000: cycles without a rising edge before sig_lost asserts (0.75 s).
REQ-003 SHALL have parameter CNT_W, default 25: width of freq_hz.
REQ-004 SHALL have parameter PER_W, default 27: width of period_cycles.
REQ-005 SHALL have port clk_50m  input  1  50 MHz system clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sig_in  input  1  asynchronous signal under measurement, e.g. a divided 2 Hz clock.
REQ-008 SHALL have port start  input  1  level request; starts a gate while the block is idle.
REQ-009 SHALL have port busy  output  1  high while a gate is open.
REQ-010 SHALL have port freq_hz  output  CNT_W  rising edges counted in the last completed gate.
REQ-011 SHALL have port meas_valid  output  1  one-cycle pulse when freq_hz updates.
REQ-012 SHALL have port period_cycles  output  PER_W  clk_50m cycles between the last two rising edges.
REQ-013 SHALL have port period_valid  output  1  one-cycle pulse when period_cycles updates.
REQ-014 SHALL have port sig_lost  output  1  high while no rising edge has been seen for LOSS_CYCLES cycles.

Function
REQ-015 SHALL synchronize sig_in through two flops and detect a rising edge (edge_p) when the synchronized value is 1 and the previous synchronized value is 0; edge_p occurs 3 cycles after the sig_in transition.
REQ-016 SHALL implement a gate FSM with states IDLE, COUNT and DONE.
REQ-017 IDLE: when start=1, SHALL clear the gate timer and edge counter and go to COUNT next cycle; busy SHALL go high in that same next cycle.
REQ-018 COUNT: the gate timer SHALL increment from 0 to GATE_CYCLES-1; every edge_p in COUNT, including the first and last gate cycles, SHALL increment the edge counter.
REQ-019 On the gate cycle GATE_CYCLES-1, the FSM SHALL go to DONE; freq_hz SHALL load the final count, including an edge_p in that same cycle.
REQ-020 DONE lasts one cycle: meas_valid=1 and busy=0; the FSM SHALL then return to IDLE, so start still high restarts on the following cycle.
REQ-021 start asserted while busy SHALL be ignored; there is no abort input.
REQ-022 The edge counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 The period timer SHALL run continuously, independent of the FSM; on each edge_p it SHALL restart at 1.
REQ-024 On every edge_p after the first since reset, period_cycles SHALL load the elapsed count and period_valid SHALL pulse for 1 cycle.
REQ-025 The period timer SHALL saturate at 2^PER_W-1; a saturated value SHALL be reported as-is.
REQ-026 sig_lost SHALL set when the cycles since the last edge_p (or since reset) reach LOSS_CYCLES, and SHALL clear in the cycle after the next edge_p.
REQ-027 freq_hz and period_cycles SHALL hold their values until they are next updated.

Reset
REQ-028 While rst_n=0: FSM=IDLE, all counters=0, freq_hz=0, period_cycles=0, busy=0, meas_valid=0, period_valid=0, sig_lost=0, synchronizer flops=0.
REQ-029 Reset during COUNT SHALL discard the partial measurement; meas_valid SHALL not pulse for it.
REQ-030 The first edge_p after reset SHALL not produce period_valid.

Structure
REQ-031 A shared package freq_meter_pkg SHALL hold the FSM state enum and the default GATE_CYCLES/LOSS_CYCLES constants, with comments deriving them from 50 MHz.
REQ-032 The synchronizer and edge detector SHALL be a sub-module sig_sync_edge, with ports clk_50m, rst_n, sig_in, sync_out, rise_p.

Verification (sim parameters: GATE_CYCLES=1000, LOSS_CYCLES=300)
REQ-033 sig_in toggles every 25 cycles (period 50), start pulsed -> meas_valid after 1001 cycles, freq_hz=20; period_cycles=50 with period_valid every 50 cycles after the second edge.
REQ-034 sig_in fed from the 50 MHz to 2 Hz divider, default parameters -> freq_hz=2 and period_cycles=25_000_000.
REQ-035 sig_in held low after edges -> sig_lost=1 exactly 300 cycles after the last edge_p; a new edge -> sig_lost=0 and no period_valid glitch beyond one pulse.
REQ-036 edge_p forced on gate cycle 0 and on gate cycle 999 -> both counted; start held high -> back-to-back gates with a single-cycle idle gap.
REQ-037 rst_n pulsed low at gate cycle 500 -> all outputs 0 immediately, no meas_valid; after release, start yields a correct full-gate result.
REQ-038 CNT_W=4, more than 15 edges per gate -> freq_hz=15 (saturated); start pulsed while busy -> no extra gate.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default timing constants for the 50 MHz frequency meter.
// All defaults derive from the 50_000_000 Hz system clock.
package freq_meter_pkg;

   // 1 s gate = 50_000_000 Hz * 1 s
   localparam int DEF_GATE_CYCLES = 50_000_000;
   // 0.75 s loss window = 50_000_000 Hz * 0.75 s
   localparam int DEF_LOSS_CYCLES = 37_500_000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } gate_state_e;

endpackage

// File: rtl/freq_meter_50m_sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a registered
// rising-edge detector; rise_p pulses 3 cycles after a sig_in rise.
module sig_sync_edge (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic sig_in,
   output logic sync_out,
   output logic rise_p
);

   logic sync_ff1;
   logic sync_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour, forming a real shift chain.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff1  <= 1'b0;
         sync_out  <= 1'b0;
         sync_prev <= 1'b0;
         rise_p    <= 1'b0;
      end else begin
         sync_ff1  <= sig_in;
         sync_out  <= sync_ff1;
         sync_prev <= sync_out;
         rise_p    <= sync_out & ~sync_prev;
      end
   end

endmodule

// File: rtl/freq_meter_50m.sv
// Gated edge counter (frequency), free-running period timer and loss
// detector for a slow asynchronous signal sampled by the 50 MHz clock.
module freq_meter_50m
   import freq_meter_pkg::*;
#(
   parameter int GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int LOSS_CYCLES = DEF_LOSS_CYCLES,
   parameter int CNT_W       = 25,
   parameter int PER_W       = 27
) (
   input  logic             clk_50m,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             start,
   output logic             busy,
   output logic [CNT_W-1:0] freq_hz,
   output logic             meas_valid,
   output logic [PER_W-1:0] period_cycles,
   output logic             period_valid,
   output logic             sig_lost
);

   localparam int GT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES + 1) : 1;
   localparam logic [GT_W-1:0]  GATE_LAST = GT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [PER_W-1:0] PER_MAX   = '1;
   localparam logic [PER_W-1:0] LOSS_LIM  = PER_W'(LOSS_CYCLES);

   gate_state_e      state, state_nx;
   logic             edge_p;
   logic             sig_sync_unused;
   logic [GT_W-1:0]  gate_tmr;
   logic             gate_last;
   logic [CNT_W-1:0] edge_cnt, cnt_nx;
   logic [PER_W-1:0] per_tmr, per_nx;
   logic             have_edge;

   sig_sync_edge u_sync (
      .clk_50m  (clk_50m),
      .rst_n    (rst_n),
      .sig_in   (sig_in),
      .sync_out (sig_sync_unused),
      .rise_p   (edge_p)
   );

   assign gate_last = (gate_tmr == GATE_LAST);
   // The final gate cycle's edge must reach freq_hz, so load the next count.
   assign cnt_nx    = (edge_p && edge_cnt != CNT_MAX) ? edge_cnt + CNT_W'(1) : edge_cnt;
   assign per_nx    = edge_p ? PER_W'(1)
                    : (per_tmr == PER_MAX) ? per_tmr : per_tmr + PER_W'(1);

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      meas_valid = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_COUNT;
         ST_COUNT: begin
            busy = 1'b1;
            if (gate_last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            meas_valid = 1'b1;
            state_nx   = ST_IDLE;
         end
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         gate_tmr <= '0;
         edge_cnt <= '0;
         freq_hz  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               gate_tmr <= '0;
               edge_cnt <= '0;
            end
            ST_COUNT: begin
               gate_tmr <= gate_tmr + GT_W'(1);
               edge_cnt <= cnt_nx;
               if (gate_last) freq_hz <= cnt_nx;
            end
            default: ;
         endcase
      end
   end

   // Period timer runs regardless of the gate; its value doubles as the
   // "cycles since last edge" count for loss detection.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         per_tmr       <= '0;
         have_edge     <= 1'b0;
         period_cycles <= '0;
         period_valid  <= 1'b0;
         sig_lost      <= 1'b0;
      end else begin
         per_tmr      <= per_nx;
         period_valid <= 1'b0;
         sig_lost     <= (per_nx >= LOSS_LIM);
         if (edge_p) begin
            have_edge <= 1'b1;
            if (have_edge) begin
               period_cycles <= per_tmr;
               period_valid  <= 1'b1;
            end
         end
      end
   end

endmodule
